// File: rtl/rv32_alu_arbiter_pkg.sv
// Shared core types for the two-requester ALU arbiter slice.
// Holds the ALU operation/flag types plus arbiter state and request bundle.
package rv32_alu_arbiter_pkg;

    typedef logic [31:0] rv32_word;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alu_op_t;

    typedef struct packed {
        logic eq;
        logic lt;
        logic ltu;
    } cmp_flags_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_RESP
    } arb_state_t;

    typedef struct packed {
        rv32_word op1;
        rv32_word op2;
        alu_op_t  op;
    } alu_req_t;

    // Winner index; meaningful only when at least one requester is valid.
    function automatic logic pick_grant(
        input logic [1:0] valid,
        input logic       last,
        input logic       fair
    );
        if (valid == 2'b11) begin
            return fair ? ~last : 1'b0;
        end
        return valid[1] & ~valid[0];
    endfunction

endpackage

// File: rtl/rv32_int_alu.sv
// Combinational RV32 integer ALU with compare flags.
module rv32_int_alu
    import rv32_alu_arbiter_pkg::*;
(
    input  alu_op_t    op,
    input  rv32_word   op1,
    input  rv32_word   op2,
    output rv32_word   result,
    output cmp_flags_t flags
);

    logic [4:0] shamt;

    assign shamt     = op2[4:0];
    assign flags.eq  = (op1 == op2);
    assign flags.lt  = ($signed(op1) < $signed(op2));
    assign flags.ltu = (op1 < op2);

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD:  result = op1 + op2;
            ALU_SUB:  result = op1 - op2;
            ALU_AND:  result = op1 & op2;
            ALU_OR:   result = op1 | op2;
            ALU_XOR:  result = op1 ^ op2;
            ALU_SLL:  result = op1 << shamt;
            ALU_SRL:  result = op1 >> shamt;
            ALU_SRA:  result = rv32_word'($signed(op1) >>> shamt);
            ALU_SLT:  result = {31'd0, flags.lt};
            ALU_SLTU: result = {31'd0, flags.ltu};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rv32_alu_arbiter.sv
// Two-requester front end sharing one ALU; one result held at a time.
module rv32_alu_arbiter
    import rv32_alu_arbiter_pkg::*;
#(
    parameter int FAIR_RR = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  rv32_word   req0_op1,
    input  rv32_word   req0_op2,
    input  alu_op_t    req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  rv32_word   req1_op1,
    input  rv32_word   req1_op2,
    input  alu_op_t    req1_op,
    output logic       resp0_valid,
    input  logic       resp0_ready,
    output rv32_word   resp0_result,
    output cmp_flags_t resp0_flags,
    output logic       resp1_valid,
    input  logic       resp1_ready,
    output rv32_word   resp1_result,
    output cmp_flags_t resp1_flags,
    output logic [31:0] ops_count
);

    arb_state_t  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    alu_req_t    req_q, req_d;
    logic [31:0] ops_count_q, ops_count_d;

    logic [1:0]  req_valid;
    logic [1:0]  resp_ready;
    alu_req_t    in_req [2];
    logic        grant;
    logic        resp_done;
    logic        can_accept;
    logic        accept;
    rv32_word    alu_result;
    cmp_flags_t  alu_flags;

    assign req_valid  = {req1_valid, req0_valid};
    assign resp_ready = {resp1_ready, resp0_ready};
    assign in_req[0]  = '{op1: req0_op1, op2: req0_op2, op: req0_op};
    assign in_req[1]  = '{op1: req1_op1, op2: req1_op2, op: req1_op};

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        req_d        = req_q;
        ops_count_d  = ops_count_q;

        grant      = pick_grant(req_valid, last_grant_q, FAIR_RR != 0);
        resp_done  = resetn && (state_q == ARB_RESP) && resp_ready[owner_q];
        can_accept = resetn && ((state_q == ARB_IDLE) || resp_done);
        accept     = can_accept && (|req_valid);

        if (resp_done) begin
            ops_count_d = ops_count_q + 32'd1;
        end

        // A completing response can hand the slot straight to a new request.
        if (accept) begin
            state_d      = ARB_RESP;
            owner_d      = grant;
            last_grant_d = grant;
            req_d        = in_req[grant];
        end else if (resp_done) begin
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            req_q        <= '0;
            ops_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            req_q        <= req_d;
            ops_count_q  <= ops_count_d;
        end
    end

    rv32_int_alu u_alu (
        .op     (req_q.op),
        .op1    (req_q.op1),
        .op2    (req_q.op2),
        .result (alu_result),
        .flags  (alu_flags)
    );

    assign req0_ready   = accept && !grant;
    assign req1_ready   = accept && grant;

    assign resp0_valid  = resetn && (state_q == ARB_RESP) && !owner_q;
    assign resp1_valid  = resetn && (state_q == ARB_RESP) && owner_q;

    assign resp0_result = resp0_valid ? alu_result : '0;
    assign resp1_result = resp1_valid ? alu_result : '0;
    assign resp0_flags  = resp0_valid ? alu_flags : '0;
    assign resp1_flags  = resp1_valid ? alu_flags : '0;

    assign ops_count    = ops_count_q;

endmodule
